// File: rtl/sort_mem_arbiter.sv
// Time-shares the sorter RAM between host port (IDLE) and sort engine (START/SORT); ownership follows registered state.
// Host is granted combinationally in IDLE only, with no queueing; the optional watchdog is enabled by SORT_WDT_EN.
module sort_mem_arbiter #(
    parameter int          AW        = 8,
    parameter int          DW        = 32,
    parameter logic [15:0] WDT_LIMIT = 16'hFFFF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          run,
    input  logic          h_req,
    input  logic          h_we,
    input  logic [AW-1:0] h_addr,
    input  logic [DW-1:0] h_din,
    output logic          h_gnt,
    output logic [DW-1:0] h_dout,
    output logic          e_start,
    input  logic          e_done,
    output logic          e_abort,
    input  logic          e_we,
    input  logic [AW-1:0] e_a,
    input  logic [DW-1:0] e_d,
    input  logic [AW-1:0] e_dpra,
    output logic          m_we,
    output logic [AW-1:0] m_a,
    output logic [DW-1:0] m_d,
    output logic [AW-1:0] m_dpra,
    input  logic [DW-1:0] m_spo,
    input  logic [DW-1:0] m_dpo,
    output logic          done,
    output logic [15:0]   cycles,
    output logic          timeout
);
    typedef enum logic [1:0] {S_IDLE, S_START, S_SORT} state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_run_q;
    logic [15:0] r_cycles;
    logic [15:0] w_cyc_inc;
    logic        w_run_ps;
    logic        w_wdt_hit;
    logic        w_unused;

    assign w_run_ps  = run & ~r_run_q;
    assign w_cyc_inc = (r_cycles == 16'hFFFF) ? r_cycles : r_cycles + 16'd1;
    assign cycles    = r_cycles;

`ifdef SORT_WDT_EN
    logic r_timeout;

    // Fires in the SORT cycle whose count reaches the limit, so the reported count equals the limit.
    assign w_wdt_hit = (r_state == S_SORT) && !e_done && (w_cyc_inc == WDT_LIMIT);
    assign e_abort   = w_wdt_hit;
    assign timeout   = r_timeout;
    assign w_unused  = ^m_dpo;

    always_ff @(posedge clk) begin
        if (rst)                       r_timeout <= 1'b0;
        else if (r_state == S_START)   r_timeout <= 1'b0;
        else if (w_wdt_hit)            r_timeout <= 1'b1;
    end
`else
    assign w_wdt_hit = 1'b0;
    assign e_abort   = 1'b0;
    assign timeout   = 1'b0;
    assign w_unused  = ^{m_dpo, WDT_LIMIT};
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_run_q  <= 1'b1;
            r_cycles <= 16'd0;
        end else begin
            r_state <= w_state_nxt;
            r_run_q <= run;
            if (r_state == S_START)     r_cycles <= 16'd0;
            else if (r_state == S_SORT) r_cycles <= w_cyc_inc;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        done        = 1'b0;
        e_start     = 1'b0;
        h_gnt       = 1'b0;
        h_dout      = '0;
        m_we        = e_we;
        m_a         = e_a;
        m_d         = e_d;
        m_dpra      = e_dpra;
        case (r_state)
            S_IDLE: begin
                done   = 1'b1;
                h_gnt  = h_req;
                h_dout = m_spo;
                m_we   = h_we & h_req;
                m_a    = h_addr;
                m_d    = h_din;
                m_dpra = '0;
                if (w_run_ps) w_state_nxt = S_START;
            end
            S_START: begin
                e_start     = 1'b1;
                w_state_nxt = S_SORT;
            end
            S_SORT: begin
                if (e_done || w_wdt_hit) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end
endmodule

// File: doc/sort_mem_arbiter.md
# sort_mem_arbiter

Owns the sort engine's 256x32 dual-port distributed RAM and time-shares it between the host load/readback port and the bubble-sort engine. Detects the `run` rising edge, hands the memory to the engine with a one-cycle start pulse, and returns it to the host when the engine reports completion. Also keeps the sort cycle count. Sits between the top-level I/O and the sorter's control unit/datapath, replacing ad hoc `done ? host : engine` muxing.

## Interface
- `AW`, 8: memory address width.
- `DW`, 32: data width.
- `WDT_LIMIT`, 16'hFFFF: watchdog cycle limit; used only with `SORT_WDT_EN`.

Ports:
- `clk` in 1: single clock; memory, host and engine are all on it.
- `rst` in 1: synchronous, active-high reset.
- `run` in 1: level from switch/bench; the rising edge is detected internally.
- `h_req` in 1: host access request, one access per cycle.
- `h_we` in 1: host write enable, qualified by `h_gnt`.
- `h_addr` in AW: host address.
- `h_din` in DW: host write data.
- `h_gnt` out 1: host access accepted this cycle.
- `h_dout` out DW: `m_spo` while in IDLE, else 0.
- `e_start` out 1: one-cycle pulse that starts the engine.
- `e_done` in 1: one-cycle completion pulse from the engine.
- `e_abort` out 1: one-cycle watchdog abort pulse.
- `e_we`, `e_a`, `e_d`, `e_dpra` in 1/AW/DW/AW: engine memory request.
- `m_we`, `m_a`, `m_d`, `m_dpra` out 1/AW/DW/AW: to the RAM.
- `m_spo`, `m_dpo` in DW: RAM read data.
- `done` out 1: 1 while in IDLE (host owns the memory).
- `cycles` out 16: sort duration in cycles.
- `timeout` out 1: the last sort was aborted by the watchdog.

## Operation
- State machine: IDLE -> START -> SORT -> IDLE.
- IDLE
  - Host owns the RAM: `m_a=h_addr`, `m_d=h_din`, `m_we=h_we&h_req`, `m_dpra=0`.
  - `h_gnt=h_req`, combinationally.
  - `run_ps=run&~run_q` moves the FSM to START.
  - A host access in the same cycle as `run_ps` is still granted and completed.
- START (exactly one cycle)
  - `e_start=1`; engine owns the RAM.
  - `cycles<=0`; `timeout<=0`.
  - `e_done` is ignored in this state.
- SORT
  - Engine owns the RAM: `m_*=e_*`.
  - `h_gnt=0`; host writes are suppressed; `h_dout=0`.
  - `cycles` increments every cycle, including the cycle in which `e_done` is seen, and saturates at 16'hFFFF.
  - `e_done` moves the FSM to IDLE.
- `run` edges outside IDLE are dropped, not queued.
- `run_q` resets to 1, so a `run` held high through reset does not start a sort.
- The engine shares `rst`; no abort handshake is needed for reset.

## Timing
- Reset values: state IDLE, `done=1`, `cycles=0`, `timeout=0`, `e_start=0`, `e_abort=0`, `run_q=1`.
- Run latency:
  - `run` is seen high at edge N, so `run_ps=1` in cycle N.
  - START is cycle N+1; `e_start=1` and `done=0`.
  - SORT begins at cycle N+2.
- `e_done` high in cycle K (SORT): IDLE from K+1, with `done=1` and the host granted in K+1.
- `cycles` = number of SORT cycles, including cycle K.
- Ownership switches only on state boundaries; the mux select is registered state, so there are no mid-cycle switches.
- Reset mid-sort: IDLE on the next edge; `cycles` and `timeout` clear; the engine resets concurrently.
- `h_dout` reflects `m_spo` combinationally (async-read RAM).

## Configuration
- `SORT_WDT_EN` defined:
  - In SORT, if `cycles==WDT_LIMIT` and `e_done=0`: pulse `e_abort` for one cycle, go to IDLE, set `timeout=1`.
  - `timeout` holds until the next START.
- `SORT_WDT_EN` undefined:
  - No watchdog logic.
  - `e_abort` and `timeout` are tied to 0.
  - SORT waits indefinitely for `e_done`; `cycles` still saturates.

## Test plan
- Reset with `run=1` held, then release: stays IDLE, `done=1`, no `e_start`.
- Host load:
  - In IDLE, write 0xDEADBEEF to addr 5 with `h_req=h_we=1`: `m_we=1`, `m_a=5`, `h_gnt=1`.
  - Read addr 5 next cycle: `h_dout=0xDEADBEEF`.
- Sort:
  - `run` rises: `e_start` pulses one cycle later, `done=0`.
  - Engine drives `e_a=3`, `e_we=1`: `m_a=3`, `m_we=1`.
  - `e_done` after 40 SORT cycles: `cycles=40`, `done=1` next cycle.
- Host blocked:
  - `h_req=h_we=1` during SORT: `h_gnt=0`, `m_we` follows `e_we` only, RAM contents unchanged at the host address.
  - A second `run` edge mid-sort is ignored; exactly one `e_start` is seen.
- Simultaneous events and reset:
  - `run_ps` together with a host write: the write lands, START follows.
  - `rst` asserted mid-SORT: IDLE, `cycles=0` next cycle.
- Watchdog (`SORT_WDT_EN`, `WDT_LIMIT=100`, `e_done` never asserted): `e_abort` pulses at the 100th SORT cycle, then IDLE with `timeout=1`, `cycles=100`.
